tick_stretcher: RTL

- Converts single-cycle tick pulses, such as those from the level-to-tick edge detector, back into a clean level of programmable length.
- Used to drive LEDs, enables and handshake levels from tick events.
- Optional retrigger extends an active level. A mandatory low gap separates consecutive levels.
- Dropped ticks are counted for debug.

---
 rtl/tick_stretcher.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tick_stretcher.sv
// tick_stretcher: stretches single-cycle ticks into registered levels
// of programmable length, with optional retrigger and a trailing low gap.
module tick_stretcher #(
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [CNT_W-1:0]  len,
    input  logic              retrig,
    output logic              level,
    output logic              done,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Reload value for the gap counter; unused when there is no gap.
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_LOAD);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [DROP_W-1:0] D_ONE = DROP_W'(1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              level_n;
    logic              done_n;
    logic              busy_n;
    logic [DROP_W-1:0] drop_n;
    logic [CNT_W-1:0]  len_eff;
    logic              drop_sat;

    // A zero length still gives a one-cycle level.
    always_comb begin
        len_eff = (len == '0) ? ONE : len;
    end

    always_comb begin
        drop_sat = (drop_cnt == '1);
    end

    // Next state, counter and registered outputs.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = 1'b0;
        done_n  = 1'b0;
        busy_n  = 1'b0;
        drop_n  = drop_cnt;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_n = HOLD;
                    cnt_n   = len_eff - ONE;
                    level_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            HOLD: begin
                if (tick && !retrig && !drop_sat) begin
                    drop_n = drop_cnt + D_ONE;
                end
                if (tick && retrig) begin
                    cnt_n   = len_eff - ONE;
                    level_n = 1'b1;
                    busy_n  = 1'b1;
                end else if (cnt != '0) begin
                    cnt_n   = cnt - ONE;
                    level_n = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    done_n = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                        cnt_n   = GAP_LD;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            GAP: begin
                if (tick && !drop_sat) begin
                    drop_n = drop_cnt + D_ONE;
                end
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n  = cnt - ONE;
                    busy_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            level    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            level    <= level_n;
            done     <= done_n;
            busy     <= busy_n;
            drop_cnt <= drop_n;
        end
    end

endmodule
